// File: rtl/frac_n_clkdiv_if.sv
`default_nettype none
// ============================================================================
// Module      : frac_n_clkdiv_if
// Description : Ratio-configuration handshake between the loop controller
//               (master) and the fractional-N divider (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface frac_n_clkdiv_if #(
    parameter int NW = 8,
    parameter int FW = 16
);
    logic          cfg_valid;
    logic          cfg_ready;
    logic [NW-1:0] cfg_n;
    logic [FW-1:0] cfg_frac;

    modport master (
        output cfg_valid,
        output cfg_n,
        output cfg_frac,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_n,
        input  cfg_frac,
        output cfg_ready
    );
endinterface
`default_nettype wire

// File: rtl/frac_n_clkdiv.sv
`default_nettype none
// ============================================================================
// Module      : frac_n_clkdiv
// Description : Fractional-N feedback divider. Each output period lasts
//               M = max(n,2) + carry VCO cycles, where carry comes from a
//               first-order phase accumulator. New ratios are staged in a
//               shadow register and only take effect at period boundaries.
// Revision    : 1.0 - initial release
// ============================================================================
module frac_n_clkdiv #(
    parameter int NW      = 8,
    parameter int FW      = 16,
    parameter int N_RESET = 4
) (
    input  wire logic        vco_out,
    input  wire logic        rst,
    input  wire logic        en,
    frac_n_clkdiv_if.slave   cfg,
    output logic             clk_out,
    output logic             div_pulse,
    output logic             carry,
    output logic [NW:0]      period_len
);

    localparam logic [NW-1:0] C_N_RESET   = NW'(N_RESET);
    localparam logic [NW:0]   C_LEN_RESET = (NW+1)'(N_RESET);
    localparam logic [NW-1:0] C_N_MIN     = NW'(2);
    localparam logic [NW:0]   C_ONE       = (NW+1)'(1);

    // Period state
    logic [NW:0]   cnt_q, cnt_d;
    logic          run_q, run_d;
    logic [FW-1:0] acc_q, acc_d;

    // Active ratio and shadow (staged) ratio
    logic [NW-1:0] n_q, n_d;
    logic [FW-1:0] frac_q, frac_d;
    logic [NW-1:0] sh_n_q, sh_n_d;
    logic [FW-1:0] sh_frac_q, sh_frac_d;
    logic          sh_full_q, sh_full_d;
    logic          cfg_ready_q, cfg_ready_d;

    // Registered outputs
    logic          clk_out_q, clk_out_d;
    logic          div_pulse_q, div_pulse_d;
    logic          carry_q, carry_d;
    logic [NW:0]   period_len_q, period_len_d;

    // Combinational helpers
    logic          w_accept;
    logic          w_boundary;
    logic [NW-1:0] w_n_sel;
    logic [FW-1:0] w_frac_sel;
    logic [NW-1:0] w_n_eff;
    logic [FW:0]   w_sum;
    logic [NW:0]   w_m;
    logic [NW:0]   w_cnt_inc;

    // Next-state logic: boundary detection, ratio staging and period sequencing
    always_comb begin
        cnt_d        = cnt_q;
        run_d        = run_q;
        acc_d        = acc_q;
        n_d          = n_q;
        frac_d       = frac_q;
        sh_n_d       = sh_n_q;
        sh_frac_d    = sh_frac_q;
        sh_full_d    = sh_full_q;
        clk_out_d    = clk_out_q;
        div_pulse_d  = div_pulse_q;
        carry_d      = carry_q;
        period_len_d = period_len_q;

        w_accept   = cfg.cfg_valid && cfg_ready_q;
        // The first enabled edge after idle starts period 0 with no extra wait
        w_boundary = en && (!run_q || (cnt_q == (period_len_q - C_ONE)));

        // A staged ratio takes priority at the boundary it was waiting for
        w_n_sel    = sh_full_q ? sh_n_q    : n_q;
        w_frac_sel = sh_full_q ? sh_frac_q : frac_q;
        w_n_eff    = (w_n_sel < C_N_MIN) ? C_N_MIN : w_n_sel;
        w_sum      = {1'b0, acc_q} + {1'b0, w_frac_sel};
        w_m        = {1'b0, w_n_eff} + {{NW{1'b0}}, w_sum[FW]};
        w_cnt_inc  = cnt_q + C_ONE;

        // Shadow hand-off happens before a same-cycle accept can refill it
        if (w_boundary && sh_full_q) begin
            n_d       = sh_n_q;
            frac_d    = sh_frac_q;
            sh_full_d = 1'b0;
        end
        if (w_accept) begin
            sh_n_d    = cfg.cfg_n;
            sh_frac_d = cfg.cfg_frac;
            sh_full_d = 1'b1;
        end
        cfg_ready_d = !sh_full_d;

        if (!en) begin
            run_d        = 1'b0;
            cnt_d        = '0;
            acc_d        = '0;
            clk_out_d    = 1'b0;
            div_pulse_d  = 1'b0;
            carry_d      = 1'b0;
            period_len_d = C_LEN_RESET;
        end else if (w_boundary) begin
            run_d        = 1'b1;
            cnt_d        = '0;
            acc_d        = w_sum[FW-1:0];
            carry_d      = w_sum[FW];
            period_len_d = w_m;
            // M >= 2 always, so k=0 is always inside the high phase
            clk_out_d    = 1'b1;
            div_pulse_d  = 1'b1;
        end else begin
            cnt_d        = w_cnt_inc;
            div_pulse_d  = 1'b0;
            clk_out_d    = (w_cnt_inc < (period_len_q >> 1));
        end
    end

    // State registers with synchronous reset that overrides all inputs
    always_ff @(posedge vco_out) begin
        if (rst) begin
            cnt_q        <= '0;
            run_q        <= 1'b0;
            acc_q        <= '0;
            n_q          <= C_N_RESET;
            frac_q       <= '0;
            sh_n_q       <= '0;
            sh_frac_q    <= '0;
            sh_full_q    <= 1'b0;
            cfg_ready_q  <= 1'b1;
            clk_out_q    <= 1'b0;
            div_pulse_q  <= 1'b0;
            carry_q      <= 1'b0;
            period_len_q <= C_LEN_RESET;
        end else begin
            cnt_q        <= cnt_d;
            run_q        <= run_d;
            acc_q        <= acc_d;
            n_q          <= n_d;
            frac_q       <= frac_d;
            sh_n_q       <= sh_n_d;
            sh_frac_q    <= sh_frac_d;
            sh_full_q    <= sh_full_d;
            cfg_ready_q  <= cfg_ready_d;
            clk_out_q    <= clk_out_d;
            div_pulse_q  <= div_pulse_d;
            carry_q      <= carry_d;
            period_len_q <= period_len_d;
        end
    end

    assign clk_out       = clk_out_q;
    assign div_pulse     = div_pulse_q;
    assign carry         = carry_q;
    assign period_len    = period_len_q;
    assign cfg.cfg_ready = cfg_ready_q;

endmodule
`default_nettype wire

// File: tb/tb_frac_n_clkdiv.sv
`default_nettype none
// ============================================================================
// Module      : tb_frac_n_clkdiv
// Description : Self-checking bench for frac_n_clkdiv. Stimulus queues the
//               hand-computed (M, carry) of each expected period; a monitor
//               pops one entry per div_pulse and also measures period length
//               and high time of every completed period.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frac_n_clkdiv;
    localparam int NW      = 8;
    localparam int FW      = 16;
    localparam int N_RESET = 4;

    logic          vco_out = 1'b0;
    logic          rst     = 1'b1;
    logic          en      = 1'b0;
    logic          clk_out;
    logic          div_pulse;
    logic          carry;
    logic [NW:0]   period_len;

    frac_n_clkdiv_if #(.NW(NW), .FW(FW)) cfg_if ();

    frac_n_clkdiv #(.NW(NW), .FW(FW), .N_RESET(N_RESET)) dut (
        .vco_out    (vco_out),
        .rst        (rst),
        .en         (en),
        .cfg        (cfg_if.slave),
        .clk_out    (clk_out),
        .div_pulse  (div_pulse),
        .carry      (carry),
        .period_len (period_len)
    );

    always #5 vco_out = ~vco_out;

    typedef struct {
        int len;
        int c;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   seg    = 0;

    // Monitor state
    int   mon_seg     = 0;
    bit   in_period   = 1'b0;
    int   cyc_cnt     = 0;
    int   hi_cnt      = 0;
    int   cur_len     = 0;
    int   seg_sum     = 0;
    int   seg_periods = 0;
    exp_t mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: one scoreboard pop per div_pulse, plus length/duty of finished periods
    always @(negedge vco_out) begin
        if (seg != mon_seg) begin
            mon_seg     = seg;
            in_period   = 1'b0;
            seg_sum     = 0;
            seg_periods = 0;
        end
        if (div_pulse === 1'b1) begin
            if (in_period) begin
                chk("period_cycles", cyc_cnt, cur_len);
                chk("high_cycles", hi_cnt, cur_len / 2);
                seg_sum     = seg_sum + cyc_cnt;
                seg_periods = seg_periods + 1;
            end
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got div_pulse=1 expected no period (t=%0t)", $time);
                cur_len = int'(period_len);
            end else begin
                mon_e = exp_q.pop_front();
                chk("period_len", period_len, mon_e.len);
                chk("carry", carry, mon_e.c);
                cur_len = mon_e.len;
            end
            in_period = 1'b1;
            cyc_cnt   = 0;
            hi_cnt    = 0;
        end else if (in_period) begin
            chk("period_len_stable", period_len, cur_len);
        end
        if (in_period) begin
            cyc_cnt = cyc_cnt + 1;
            if (clk_out === 1'b1) hi_cnt = hi_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge vco_out);
        #1;
    endtask

    task automatic push_exp(input int len, input int c);
        exp_t e;
        e.len = len;
        e.c   = c;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst              = 1'b1;
        en               = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        seg++;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Load the shadow register while the divider is idle
    task automatic load_cfg(input int n, input int frac);
        cfg_if.cfg_n     = NW'(n);
        cfg_if.cfg_frac  = FW'(frac);
        cfg_if.cfg_valid = 1'b1;
        tick();
        cfg_if.cfg_valid = 1'b0;
        chk("cfg_ready_after_accept", cfg_if.cfg_ready, 0);
    endtask

    task automatic wait_drain(input int budget);
        int b;
        b = budget;
        while (exp_q.size() != 0 && b > 0) begin
            @(posedge vco_out);
            b--;
        end
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d periods pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic abort_seg();
        en = 1'b0;
        seg++;
        tick();
    endtask

    task automatic run_seg(input int budget);
        en = 1'b1;
        wait_drain(budget);
        abort_seg();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_clk_out"}, clk_out, 0);
        chk({tag, "_div_pulse"}, div_pulse, 0);
        chk({tag, "_carry"}, carry, 0);
        chk({tag, "_period_len"}, period_len, N_RESET);
    endtask

    initial begin
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_n     = '0;
        cfg_if.cfg_frac  = '0;

        // Reset state, and reset winning over en and cfg_valid
        do_reset();
        rst = 1'b1;
        tick();
        chk_reset_outputs("reset");
        chk("reset_cfg_ready", cfg_if.cfg_ready, 1);
        en               = 1'b1;
        cfg_if.cfg_n     = NW'(9);
        cfg_if.cfg_valid = 1'b1;
        tick();
        chk_reset_outputs("reset_wins");
        chk("reset_wins_cfg_ready", cfg_if.cfg_ready, 1);
        do_reset();

        // n=4 integer divide
        for (int i = 0; i < 4; i++) push_exp(4, 0);
        run_seg(200);

        // n=5 integer divide: 2 high / 3 low
        do_reset();
        load_cfg(5, 0);
        for (int i = 0; i < 4; i++) push_exp(5, 0);
        run_seg(200);

        // frac=0x8000: 4,5,4,5
        do_reset();
        load_cfg(4, 16'h8000);
        for (int i = 0; i < 6; i++) push_exp((i % 2) ? 5 : 4, i % 2);
        run_seg(200);

        // frac=0x4000: 4,4,4,5 repeating; 1024 full periods total 4352 cycles
        do_reset();
        load_cfg(4, 16'h4000);
        for (int i = 0; i < 1025; i++) push_exp(((i % 4) == 3) ? 5 : 4, ((i % 4) == 3) ? 1 : 0);
        en = 1'b1;
        wait_drain(6000);
        chk("avg_periods", seg_periods, 1024);
        chk("avg_cycles", seg_sum, 4352);
        abort_seg();

        // Mid-period ratio change: offer at k=1, second offer ignored
        do_reset();
        push_exp(4, 0);
        for (int i = 0; i < 3; i++) push_exp(6, 0);
        en = 1'b1;
        tick();                                  // period 0, k=0
        tick();                                  // k=1
        cfg_if.cfg_n     = NW'(6);
        cfg_if.cfg_frac  = '0;
        cfg_if.cfg_valid = 1'b1;
        tick();                                  // k=2, accepted
        chk("cfg_ready_busy", cfg_if.cfg_ready, 0);
        cfg_if.cfg_n = NW'(9);                   // offered while busy
        tick();                                  // k=3
        tick();                                  // period 1, k=0
        cfg_if.cfg_valid = 1'b0;
        chk("cfg_ready_freed", cfg_if.cfg_ready, 1);
        wait_drain(200);
        abort_seg();

        // n=1 clamps to 2
        do_reset();
        load_cfg(1, 0);
        for (int i = 0; i < 4; i++) push_exp(2, 0);
        run_seg(200);

        // Largest ratio with carry: 255,256
        do_reset();
        load_cfg(255, 16'h8000);
        for (int i = 0; i < 4; i++) push_exp((i % 2) ? 256 : 255, i % 2);
        run_seg(1500);

        // Reset at k=2 of a 5-cycle period discards a pending shadow word
        do_reset();
        load_cfg(5, 0);
        push_exp(5, 0);
        push_exp(5, 0);
        en = 1'b1;
        tick();                                  // period 0, k=0
        repeat (4) tick();                       // k=4
        tick();                                  // period 1, k=0
        tick();                                  // k=1
        cfg_if.cfg_n     = NW'(7);
        cfg_if.cfg_valid = 1'b1;
        tick();                                  // k=2, shadow loaded
        cfg_if.cfg_valid = 1'b0;
        chk("midrst_shadow_full", cfg_if.cfg_ready, 0);
        rst = 1'b1;
        en  = 1'b0;
        seg++;
        tick();
        chk_reset_outputs("midrst");
        chk("midrst_cfg_ready", cfg_if.cfg_ready, 1);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) push_exp(4, 0);
        run_seg(200);

        // en low for 10 cycles mid-sequence; accumulator restarts from 0
        do_reset();
        load_cfg(4, 16'h8000);
        push_exp(4, 0);
        en = 1'b1;
        tick();                                  // period 0, k=0
        tick();                                  // k=1
        abort_seg();
        for (int i = 0; i < 10; i++) begin
            chk_reset_outputs("en_low");
            tick();
        end
        for (int i = 0; i < 4; i++) push_exp((i % 2) ? 5 : 4, i % 2);
        run_seg(200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
